rf_write_queue: RTL and testbench
=================================

# rf_write_queue

Write-back buffer directly upstream of the 32x32 register file's single write port. It accepts register write requests from the execute/write-back side, queues up to DEPTH of them in order, and drains one per cycle into the register file (`WriteEn`/`WriteAddr`/`data_i`). It also provides two combinational bypass lookups, aligned with read ports A and B, so a reader can get the newest pending value for a register that has not yet reached the file.

## Interface
- `DEPTH`, 4 — queue entries; power of two, at least 2.
- `DATA_W`, 32 — data width; matches the register file.
- `ADDR_W`, 5 — register address width; matches the register file.
- `Clk` input 1 — clock; all state updates on the rising edge.
- `Rst_n` input 1 — asynchronous, active-low reset.
- `in_valid` input 1 — write request present.
- `in_ready` output 1 — queue can accept a request this cycle.
- `in_addr` input ADDR_W — destination register.
- `in_data` input DATA_W — write data.
- `DrainEn` input 1 — permits draining; 0 holds the queue.
- `WriteEn` output 1 — to register file `WriteEn`.
- `WriteAddr` output ADDR_W — to register file `WriteAddr`.
- `data_o` output DATA_W — to register file `data_i`.
- `LookupA` input ADDR_W — bypass query A; tie to the register file `ReadA`.
- `HitA` output 1 — a pending entry matches `LookupA`.
- `HitDataA` output DATA_W — newest pending data for `LookupA`.
- `LookupB`, `HitB`, `HitDataB` — the same as the A set, for port B.
- `Count` output $clog2(DEPTH+1) — number of occupied entries.
- `Full` output 1 — `Count == DEPTH`.
- `Empty` output 1 — `Count == 0`.

## Operation
- Storage is a circular buffer: DEPTH entries of {valid, addr, data}, plus a write pointer, a read pointer and a count.
- **Enqueue:** happens when `in_valid && in_ready`; `in_ready = !Full && Rst_n`.
  - `in_ready` does not depend on a same-cycle dequeue. A full queue always refuses a request, even if it is draining.
- **Dequeue:** happens when `WriteEn` is 1, where `WriteEn = !Empty && DrainEn`.
  - `WriteAddr` and `data_o` always show the head entry.
  - When `Empty`, `WriteAddr` and `data_o` are 0.
  - The head entry is removed on the same edge at which the register file samples it.
- **Simultaneous enqueue and dequeue:** `Count` is unchanged, and both pointers advance.
- **Pointer wrap:** pointers wrap modulo DEPTH. Order is strictly FIFO.
- **Address 0:** needs no special case; it is queued and drained like any other address.
- **Duplicate addresses:** several pending entries may target the same register. All are drained in order, so the last one wins in the file.
- **Bypass:**
  - `HitX` = 1 if any valid entry's addr equals `LookupX`.
  - `HitDataX` = data of the youngest matching entry, i.e. the one closest to the write pointer.
  - When there is no hit, `HitDataX` = 0.
  - The lookup covers stored entries only. A same-cycle `in_*` request is not visible.
  - The head entry being drained this cycle is still visible; from the next cycle the register file holds it.
- **Reset (`Rst_n` low, asynchronous):**
  - Pointers, `Count` and all valid bits clear.
  - Outputs: `Empty` 1, `Full` 0, `WriteEn` 0, `in_ready` 0, `HitA`/`HitB` 0, data outputs 0.
  - A reset asserted mid-operation discards every pending entry. No partial write reaches the file.

## Timing
- Enqueue-to-`WriteEn` latency is 1 cycle: an entry accepted at edge N is on the outputs after N and is written into the file at edge N+1, provided `DrainEn` is 1.
- Peak throughput is 1 enqueue and 1 dequeue per cycle.
- `WriteEn`, `WriteAddr`, `data_o`, `Full`, `Empty` and `Count` come from registers through decode logic only. They do not depend on `in_*`.
- `HitX`/`HitDataX` are combinational from `LookupX` and the stored state, with no dependence on `in_*`.
- `in_ready` rises the cycle after a dequeue takes `Full` back to 0.
- With `DrainEn` at 0, the queue fills to DEPTH and then holds. Contents and order are unaffected.

## Test plan
- **Reset values:** assert `Rst_n` = 0 mid-stream with 3 entries queued → `Count` = 0, `Empty` = 1, `WriteEn` = 0, `HitA` = 0 immediately; after release `in_ready` = 1 and no stale write ever appears.
- **Single write:** `DrainEn` = 1; enqueue (addr 7, 0x0000_0007) → next cycle `WriteEn` = 1, `WriteAddr` = 7, `data_o` = 7; one cycle later `Empty` = 1. Register file read A of 7 returns 7.
- **Fill and drain:** `DrainEn` = 0; enqueue addrs 1..5 with data = addr → `in_ready` = 0 after the 4th, and the 5th is not accepted until a drain. Set `DrainEn` = 1 → writes 1, 2, 3, 4 in order on consecutive cycles, then 5 once accepted.
- **Bypass youngest-wins:** hold drain; enqueue (9, 0xAAAA), then (9, 0xBBBB); `LookupA` = 9 → `HitA` = 1, `HitDataA` = 0xBBBB. `LookupB` = 3 → `HitB` = 0, `HitDataB` = 0.
- **Concurrent enqueue/dequeue with wrap:** stream 20 requests back to back with `DrainEn` = 1 → `Count` stays at 1, writes appear in order, and pointers wrap at least 4 times.
- **Drain pause:** with 2 entries queued, toggle `DrainEn` 1→0→1 → `WriteEn` follows `DrainEn`, and no entry is lost or duplicated.

Source files
------------

// File: rtl/rf_write_queue.sv
// In-order write-back buffer feeding the register file's single write port,
// with two combinational bypass lookups returning the newest pending value.
module rf_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       DrainEn,
    output logic                       WriteEn,
    output logic [ADDR_W-1:0]          WriteAddr,
    output logic [DATA_W-1:0]          data_o,
    input  logic [ADDR_W-1:0]          LookupA,
    output logic                       HitA,
    output logic [DATA_W-1:0]          HitDataA,
    input  logic [ADDR_W-1:0]          LookupB,
    output logic                       HitB,
    output logic [DATA_W-1:0]          HitDataB,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Full,
    output logic                       Empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              enq;
    logic              deq;

    // Handshake: a request transfers on a rising edge where in_valid and
    // in_ready are both 1; in_ready depends only on the registered count,
    // never on a same-cycle drain, so a full queue refuses even while draining.
    assign Full     = (count_q == CNT_W'(DEPTH));
    assign Empty    = (count_q == '0);
    assign Count    = count_q;
    assign in_ready = !Full && Rst_n;
    assign enq      = in_valid && in_ready;

    assign WriteEn   = !Empty && DrainEn;
    assign deq       = WriteEn;
    assign WriteAddr = Empty ? '0 : addr_q[rd_ptr];
    assign data_o    = Empty ? '0 : data_q[rd_ptr];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (deq) begin
                rd_ptr          <= rd_ptr + 1'b1;
                valid_q[rd_ptr] <= 1'b0;
            end
            if (enq) begin
                wr_ptr          <= wr_ptr + 1'b1;
                valid_q[wr_ptr] <= 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: every read is qualified by a valid bit or Empty.
    always_ff @(posedge Clk) begin
        if (enq) begin
            addr_q[wr_ptr] <= in_addr;
            data_q[wr_ptr] <= in_data;
        end
    end

    // Scan from head towards tail so the last match is the youngest entry.
    always_comb begin
        logic [PTR_W-1:0] idx;
        HitA     = 1'b0;
        HitDataA = '0;
        HitB     = 1'b0;
        HitDataB = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (valid_q[idx] && addr_q[idx] == LookupA) begin
                HitA     = 1'b1;
                HitDataA = data_q[idx];
            end
            if (valid_q[idx] && addr_q[idx] == LookupB) begin
                HitB     = 1'b1;
                HitDataB = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_rf_write_queue.sv
// Bench for rf_write_queue: directed scenarios plus random traffic, checked
// against a pending-entry queue model and a drain scoreboard.
module tb_rf_write_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int W     = AW + DW;

    logic          Clk;
    logic          Rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          DrainEn;
    logic          WriteEn;
    logic [AW-1:0] WriteAddr;
    logic [DW-1:0] data_o;
    logic [AW-1:0] LookupA;
    logic          HitA;
    logic [DW-1:0] HitDataA;
    logic [AW-1:0] LookupB;
    logic          HitB;
    logic [DW-1:0] HitDataB;
    logic [CW-1:0] Count;
    logic          Full;
    logic          Empty;

    logic [W-1:0] exp_q[$];   // scoreboard: accepted writes awaiting the drain port
    logic [W-1:0] pend_q[$];  // model: entries currently held, oldest first
    int           n_checks;
    int           n_fail;
    logic         lookup_rand;

    rf_write_queue #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .DrainEn(DrainEn), .WriteEn(WriteEn), .WriteAddr(WriteAddr), .data_o(data_o),
        .LookupA(LookupA), .HitA(HitA), .HitDataA(HitDataA),
        .LookupB(LookupB), .HitB(HitB), .HitDataB(HitDataB),
        .Count(Count), .Full(Full), .Empty(Empty)
    );

    // Clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain FIFO semantics, acceptance limited only by occupancy.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend_q.delete();
            exp_q.delete();
        end else begin
            automatic bit take = in_valid && (pend_q.size() < DEPTH);
            if (DrainEn && pend_q.size() > 0) void'(pend_q.pop_front());
            if (take) begin
                pend_q.push_back({in_addr, in_data});
                exp_q.push_back({in_addr, in_data});
            end
        end
    end

    // Monitor: compares all outputs against the model away from the active edge.
    always @(negedge Clk) begin
        automatic int           n   = pend_q.size();
        automatic logic [W-1:0] hd  = (n > 0) ? pend_q[0] : '0;
        automatic logic         ha  = 1'b0;
        automatic logic         hb  = 1'b0;
        automatic logic [DW-1:0] da = '0;
        automatic logic [DW-1:0] db = '0;
        automatic logic [W-1:0] got;
        chk("count", Count, n);
        chk("empty", Empty, n == 0);
        chk("full", Full, n == DEPTH);
        chk("in_ready", in_ready, Rst_n && n < DEPTH);
        chk("write_en", WriteEn, Rst_n && DrainEn && n > 0);
        chk("write_addr", WriteAddr, hd[W-1:DW]);
        chk("data_o", data_o, hd[DW-1:0]);
        foreach (pend_q[i]) begin
            if (pend_q[i][W-1:DW] == LookupA) begin ha = 1'b1; da = pend_q[i][DW-1:0]; end
            if (pend_q[i][W-1:DW] == LookupB) begin hb = 1'b1; db = pend_q[i][DW-1:0]; end
        end
        chk("hit_a", HitA, ha);
        chk("hit_data_a", HitDataA, da);
        chk("hit_b", HitB, hb);
        chk("hit_data_b", HitDataB, db);
        if (WriteEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                got = exp_q.pop_front();
                chk("drain_addr", WriteAddr, got[W-1:DW]);
                chk("drain_data", data_o, got[DW-1:0]);
            end
        end
    end

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (lookup_rand) begin
                LookupA = AW'($urandom_range(0, 9));
                LookupB = AW'($urandom_range(0, 9));
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Holds a request until the edge at which it is accepted (bounded).
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge Clk);
            ok = in_ready;
            step();
            if (ok) break;
            if (t == 49) chk("send_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int t = 0; t < 50; t++) begin
            if (Empty) return;
            step();
        end
        chk("drain_timeout", Empty, 1);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        lookup_rand = 1'b1;
        Rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_addr     = '0;
        in_data     = '0;
        DrainEn     = 1'b0;
        LookupA     = '0;
        LookupB     = '0;
        repeat (3) step();
        Rst_n = 1'b1;
        #1;
        chk("ready_after_reset", in_ready, 1);

        // Single write: visible on the write port right after acceptance
        DrainEn = 1'b1;
        send(5'd7, 32'h7);
        chk("single_write_en", WriteEn, 1);
        chk("single_write_addr", WriteAddr, 7);
        chk("single_write_data", data_o, 32'h7);
        step();
        chk("single_empty", Empty, 1);

        // Fill with drain held, fifth request refused until a drain frees a slot
        DrainEn = 1'b0;
        for (int a = 1; a <= 4; a++) send(AW'(a), DW'(a));
        chk("fill_full", Full, 1);
        chk("fill_not_ready", in_ready, 0);
        in_valid = 1'b1;
        in_addr  = 5'd5;
        in_data  = 32'd5;
        repeat (2) step();
        chk("fill_held_count", Count, 4);
        DrainEn = 1'b1;
        send(5'd5, 32'd5);
        wait_empty();

        // Bypass youngest-wins
        DrainEn     = 1'b0;
        lookup_rand = 1'b0;
        send(5'd9, 32'hAAAA);
        send(5'd9, 32'hBBBB);
        LookupA = 5'd9;
        LookupB = 5'd3;
        #1;
        chk("bypass_hit_a", HitA, 1);
        chk("bypass_data_a", HitDataA, 32'hBBBB);
        chk("bypass_hit_b", HitB, 0);
        chk("bypass_data_b", HitDataB, 0);
        step();
        DrainEn = 1'b1;
        wait_empty();
        lookup_rand = 1'b1;

        // Back-to-back stream with concurrent drain: occupancy stays at one
        for (int i = 0; i < 20; i++) begin
            send(AW'($urandom_range(0, 31)), $urandom);
            chk("stream_count", Count, 1);
        end
        wait_empty();

        // Drain pause
        DrainEn = 1'b0;
        send(5'd11, 32'h1111);
        send(5'd12, 32'h2222);
        DrainEn = 1'b1;
        #1;
        chk("pause_we_on", WriteEn, 1);
        step();
        DrainEn = 1'b0;
        #1;
        chk("pause_we_off", WriteEn, 0);
        step();
        DrainEn = 1'b1;
        wait_empty();

        // Reset asserted mid-operation with three entries queued
        DrainEn = 1'b0;
        send(5'd2, 32'h22);
        send(5'd4, 32'h44);
        send(5'd6, 32'h66);
        lookup_rand = 1'b0;
        LookupA     = 5'd4;
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rst_count", Count, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_write_en", WriteEn, 0);
        chk("rst_hit_a", HitA, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (2) step();
        Rst_n = 1'b1;
        #1;
        chk("rst_release_ready", in_ready, 1);
        DrainEn = 1'b1;
        repeat (3) step();
        lookup_rand = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_addr  = AW'($urandom_range(0, 7));
            in_data  = $urandom;
            DrainEn  = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        DrainEn  = 1'b1;
        wait_empty();
        step();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
